// File: rtl/pll_startup_ctrl_pkg.sv
// Shared constants for the PLL startup controller: state encodings,
// counter/retry widths, default timing parameters and saturating helpers.
package pll_ctrl_pkg;

  localparam int CNT_W   = 24;
  localparam int RETRY_W = 4;
  localparam int STATE_W = 3;

  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65535;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

  // Encodings are visible on o_state (debug / LED), so they are fixed values.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } pll_state_e;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  // Counter value seen on the last cycle of an N-cycle interval (counter starts at 0).
  function automatic logic [CNT_W-1:0] cnt_last(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
    return (v == RETRY_MAX) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/pll_startup_ctrl_if.sv
// Signal bundle between the PLL startup controller and the PLL / fabric side.
// master: controller view; slave: PLL, fabric or testbench view.
interface pll_startup_ctrl_if;
  import pll_ctrl_pkg::*;

  logic               i_pll_lock;
  logic               i_restart;
  logic               o_pll_resetb;
  logic               o_pll_bypass;
  logic               o_ready;
  logic               o_fault;
  logic [RETRY_W-1:0] o_retry_count;
  logic [STATE_W-1:0] o_state;

  modport master (
    input  i_pll_lock,
    input  i_restart,
    output o_pll_resetb,
    output o_pll_bypass,
    output o_ready,
    output o_fault,
    output o_retry_count,
    output o_state
  );

  modport slave (
    output i_pll_lock,
    output i_restart,
    input  o_pll_resetb,
    input  o_pll_bypass,
    input  o_ready,
    input  o_fault,
    input  o_retry_count,
    input  o_state
  );

endinterface

// File: rtl/pll_startup_ctrl_sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level (PLL LOCK).
module sync_ff2 (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  // Shift the async level through two flops; both clear to 0 in reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/pll_startup_ctrl.sv
// PLL startup sequencer: holds the PLL in reset, waits for lock with a
// timeout and bounded retries, qualifies lock for a stable interval, then
// flags the PLL clock ready. Lock loss in RUN restarts the whole sequence.
//
// Build option: define PLL_BYPASS_ON_FAULT_EN to drive o_pll_bypass high in
// FAULT so the fabric falls back to the reference clock; otherwise the
// bypass output is tied low.
//
// state         | meaning
// --------------+----------------------------------------------------------
// RESET_HOLD(0) | PLL RESETB low for RESET_CYCLES cycles
// WAIT_LOCK (1) | RESETB high, waiting up to LOCK_TIMEOUT cycles for lock
// SETTLE    (2) | lock seen, needs STABLE_CYCLES consecutive lock cycles
// RUN       (3) | PLL clock valid, o_ready high
// FAULT     (4) | retries exhausted, PLL held in reset until i_restart
module pll_startup_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input logic              i_clock,
  input logic              i_reset_n,
  pll_startup_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0]   RESET_LAST  = cnt_last(RESET_CYCLES);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = cnt_last(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0]   STABLE_LAST = cnt_last(STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               cnt_clr;

  logic resetb_q, resetb_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

  sync_ff2 u_lock_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_d       (bus.i_pll_lock),
    .o_q       (lock_s)
  );

  // Next-state, retry bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_clr = 1'b0;

    if (bus.i_restart) begin
      // Restart overrides everything, even a restart while already in RESET_HOLD.
      state_d = ST_RESET_HOLD;
      retry_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_RESET_HOLD: begin
          if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so it wins on the timeout cycle.
          if (lock_s) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == LOCK_LAST) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_sat_inc(retry_q);
              state_d = ST_RESET_HOLD;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end
        ST_SETTLE: begin
          // A lock dropout only restarts qualification; it is not a failed attempt.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET_HOLD;
            retry_d = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET_HOLD;
          retry_d = '0;
        end
      endcase
    end

    cnt_d = (cnt_clr || (state_d != state_q)) ? '0 : cnt_sat_inc(cnt_q);

    // Outputs are decoded from the next state so they change on the same edge as the state.
    resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
    fault_d  = (state_d == ST_FAULT);
  end

  // State, counter, retry count and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_RESET_HOLD;
      cnt_q    <= '0;
      retry_q  <= '0;
      resetb_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      resetb_q <= resetb_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

`ifdef PLL_BYPASS_ON_FAULT_EN
  logic bypass_q;

  // Bypass follows FAULT so the fabric runs from the reference clock after failure.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bypass_q <= 1'b0;
    end else begin
      bypass_q <= fault_d;
    end
  end

  assign bus.o_pll_bypass = bypass_q;
`else
  assign bus.o_pll_bypass = 1'b0;
`endif

  assign bus.o_pll_resetb  = resetb_q;
  assign bus.o_ready       = ready_q;
  assign bus.o_fault       = fault_q;
  assign bus.o_retry_count = retry_q;
  assign bus.o_state       = state_q;

`ifndef SYNTHESIS
  // Output decodes must always agree with the state register.
  a_ready_only_run : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    ready_q == (state_q == ST_RUN));
  a_fault_only_fault : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    fault_q == (state_q == ST_FAULT));
  a_resetb_decode : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    resetb_q == ((state_q == ST_WAIT_LOCK) || (state_q == ST_SETTLE) || (state_q == ST_RUN)));
  a_retry_bound : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    retry_q <= RETRY_LIMIT);
`endif

endmodule

// File: doc/pll_startup_ctrl.md
PLL_STARTUP_CTRL -- requirements
Module: pll_startup_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 16: cycles the PLL is held in reset per attempt, range 1..2^24-1.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK before the attempt fails, range 1..2^24-1.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before ready, range 1..2^24-1.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3: failed attempts retried before FAULT, range 0..15.
REQ-005 The block SHALL have the ports, with one clock and an asynchronous active-low reset, as follows: i_clock  in  1  sole clock, rising edge.
REQ-006 i_reset_n  in  1  asynchronous active-low reset.
REQ-007 i_pll_lock  in  1  PLL LOCK output, asynchronous to i_clock.
REQ-008 i_restart  in  1  single-cycle synchronous restart request.
REQ-009 o_pll_resetb  out  1  drives PLL RESETB; 0 holds the PLL in reset.
REQ-010 o_pll_bypass  out  1  drives PLL BYPASS.
REQ-011 o_ready  out  1  PLL clock valid for downstream logic.
REQ-012 o_fault  out  1  retries exhausted.
REQ-013 o_retry_count  out  4  failed attempts in the current startup sequence.
REQ-014 o_state  out  3  current state encoding, for debug and LED display.

Function
REQ-015 i_pll_lock SHALL pass through a 2-flop synchronizer, and all decisions SHALL use its output (lock_s), giving 2 cycles of input latency.
REQ-016 The states SHALL be RESET_HOLD=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4, and all outputs SHALL be registered.
REQ-017 In RESET_HOLD, o_pll_resetb SHALL be 0; after exactly RESET_CYCLES cycles the block SHALL go to WAIT_LOCK with the cycle counter cleared.
REQ-018 In WAIT_LOCK, lock_s=1 SHALL go to SETTLE with the counter cleared.
REQ-019 In WAIT_LOCK, if LOCK_TIMEOUT cycles elapse without lock and o_retry_count<MAX_RETRIES, the block SHALL increment o_retry_count and go to RESET_HOLD.
REQ-020 In WAIT_LOCK, if LOCK_TIMEOUT cycles elapse without lock and o_retry_count=MAX_RETRIES, the block SHALL go to FAULT.
REQ-021 When lock arrives on the timeout cycle, the lock SHALL win.
REQ-022 In SETTLE, STABLE_CYCLES consecutive cycles of lock_s=1 SHALL go to RUN; lock_s=0 on any cycle SHALL go to WAIT_LOCK with the counter cleared and no retry consumed.
REQ-023 In RUN, o_ready SHALL be 1; lock_s=0 SHALL go to RESET_HOLD, clear o_retry_count, and drop o_ready on the same edge.
REQ-024 In FAULT, o_fault SHALL be 1 and o_pll_resetb SHALL be 0; the block SHALL stay in FAULT until i_restart.
REQ-025 i_restart=1 in any state SHALL go to RESET_HOLD, clear o_retry_count and the counter, and take priority over every other transition.
REQ-026 o_ready SHALL be 1 only in RUN, o_fault only in FAULT, and o_pll_resetb SHALL be 1 only in WAIT_LOCK, SETTLE and RUN.
REQ-027 The counter SHALL be 24 bits, saturate rather than wrap, and clear on every state change.
REQ-028 o_retry_count SHALL saturate at 15.

Reset
REQ-029 While i_reset_n=0, the block SHALL be in RESET_HOLD with counter=0, o_pll_resetb=0, o_pll_bypass=0, o_ready=0, o_fault=0, o_retry_count=0, o_state=0 and synchronizer flops=0.
REQ-030 Reset asserted mid-operation, including in RUN, SHALL drop o_ready asynchronously.
REQ-031 Release of i_reset_n SHALL begin a fresh RESET_HOLD of RESET_CYCLES cycles.

Configuration
REQ-032 With macro PLL_BYPASS_ON_FAULT_EN defined, o_pll_bypass SHALL be 1 in FAULT and 0 elsewhere, so the fabric runs on the reference clock after failure.
REQ-033 Without PLL_BYPASS_ON_FAULT_EN, o_pll_bypass SHALL be constant 0 and all other behaviour SHALL be identical.

Structure
REQ-034 Package pll_ctrl_pkg SHALL hold the state encodings, counter width (24), retry-count width (4) and default parameter constants.
REQ-035 The synchronizer SHALL be sub-module sync_ff2 (1-bit, 2 flops, async active-low reset to 0); all other logic SHALL be in pll_startup_ctrl.

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-036 Release reset, raise i_pll_lock at cycle 10 -> o_pll_resetb rises after 4 cycles, SETTLE 2 cycles after lock, o_ready=1 exactly 8 cycles later.
REQ-037 i_pll_lock held 0 -> o_retry_count steps 1, 2, then FAULT with o_fault=1 after the third timeout; o_pll_bypass=1 only with PLL_BYPASS_ON_FAULT_EN.
REQ-038 Lock glitch low for 1 cycle at SETTLE cycle 5 -> return to WAIT_LOCK, o_retry_count unchanged, full 8-cycle settle repeated.
REQ-039 Lock dropped in RUN -> o_ready=0 three edges later, RESET_HOLD, o_retry_count=0.
REQ-040 i_restart in FAULT and on the WAIT_LOCK timeout cycle -> RESET_HOLD next cycle, retries cleared.
REQ-041 i_reset_n pulsed low in RUN -> o_ready=0 immediately, all outputs at reset values.
